alu_serial_seq: RTL and testbench

Bit-serial sequencer that drives the team's 1-bit ALU slice: accepts WIDTH-bit operands plus a 2-bit opcode, feeds one bit pair per clock LSB-first, and registers the slice carry between bits. Collects the slice output into a WIDTH-bit result and signals completion with a one-cycle done pulse. Sits between a host (register file or test controller) and one combinational ALU slice.

---
 rtl/alu_serial_seq_pkg.sv | 15 +
 rtl/alu_serial_dp.sv | 58 +++++
 rtl/alu_serial_seq.sv | 101 ++++++++++
 tb/tb_alu_serial_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_serial_seq_pkg.sv
// rtl/alu_serial_seq_pkg.sv - opcode constants and FSM state encoding for the bit-serial ALU sequencer
package alu_serial_seq_pkg;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_NOT  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_serial_dp.sv
// rtl/alu_serial_dp.sv - operand shift registers, carry register, bit counter and result collector
module alu_serial_dp
  import alu_serial_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin_init,
  input  logic             alu_out,
  input  logic             alu_cout,
  output logic             a_bit,
  output logic             b_bit,
  output logic             carry,
  output logic [1:0]       op_q,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      result <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      op_q   <= 2'b00;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      op_q  <= op;
      carry <= (op == OP_ADD) ? cin_init : 1'b0;
      cnt   <= '0;
    end else if (shift) begin
      // Slice output enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
      result <= {alu_out, result[WIDTH-1:1]};
      a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
      b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
      carry  <= (op_q == OP_ADD) ? alu_cout : 1'b0;
      cnt    <= cnt + 1'b1;
    end
  end

  assign a_bit = a_sh[0];
  assign b_bit = b_sh[0];
  assign last  = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_serial_seq.sv
// rtl/alu_serial_seq.sv - bit-serial sequencer driving an external 1-bit ALU slice LSB-first
module alu_serial_seq
  import alu_serial_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin_init,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_c,
  input  logic             alu_out,
  input  logic             alu_cout
);

  state_t     state;
  logic       load;
  logic       shift;
  logic       a_bit;
  logic       b_bit;
  logic       carry;
  logic       last;
  logic [1:0] op_q;

  assign load  = (state == ST_IDLE) && start;
  assign shift = (state == ST_SHIFT);

  alu_serial_dp #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_dp (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .shift    (shift),
    .op       (op),
    .a        (a),
    .b        (b),
    .cin_init (cin_init),
    .alu_out  (alu_out),
    .alu_cout (alu_cout),
    .a_bit    (a_bit),
    .b_bit    (b_bit),
    .carry    (carry),
    .op_q     (op_q),
    .result   (result),
    .last     (last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (last) begin
            state <= ST_DONE;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          done      <= 1'b1;
          carry_out <= (op_q == OP_ADD) ? carry : 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // busy is high exactly while in SHIFT, so it doubles as the slice-drive enable.
  assign alu_a   = busy ? a_bit : 1'b0;
  assign alu_b   = busy ? b_bit : 1'b0;
  assign alu_cin = busy ? carry : 1'b0;
  assign alu_c   = busy ? op_q : 2'b00;

endmodule

// File: tb/tb_alu_serial_seq.sv
// tb/tb_alu_serial_seq.sv - self-checking bench for alu_serial_seq with a behavioural 1-bit ALU slice
module tb_alu_serial_seq;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin_init = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             alu_a;
  logic             alu_b;
  logic             alu_cin;
  logic [1:0]       alu_c;
  logic             alu_out;
  logic             alu_cout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_serial_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin_init  (cin_init),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_c     (alu_c),
    .alu_out   (alu_out),
    .alu_cout  (alu_cout)
  );

  // One-bit ALU slice
  always_comb begin
    alu_out  = 1'b0;
    alu_cout = 1'b0;
    case (alu_c)
      2'b00: alu_out = alu_a;
      2'b01: begin
        alu_out  = alu_a ^ alu_b ^ alu_cin;
        alu_cout = (alu_a & alu_b) | (alu_a & alu_cin) | (alu_b & alu_cin);
      end
      2'b10: alu_out = alu_a & alu_b;
      default: alu_out = ~alu_a;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: what the whole operation should produce.
  function automatic int ref_result(input logic [1:0] o, input int x, input int y, input int c);
    int s;
    case (o)
      2'b00: s = x;
      2'b01: s = (x + y + c) % (1 << WIDTH);
      2'b10: s = x & y;
      default: s = (~x) & ((1 << WIDTH) - 1);
    endcase
    return s;
  endfunction

  function automatic int ref_carry(input logic [1:0] o, input int x, input int y, input int c);
    return (o == 2'b01) ? (x + y + c) / (1 << WIDTH) : 0;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] o, input logic [WIDTH-1:0] x,
                        input logic [WIDTH-1:0] y, input logic c);
    int busy_n;
    int done_at;
    @(negedge clk);
    op = o; a = x; b = y; cin_init = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_n = 0;
    done_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_n++;
      if (done) begin
        done_at = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, done_at, WIDTH + 1);
    check({tag, "_busy_cycles"}, busy_n, WIDTH);
    check({tag, "_result"}, {24'd0, result}, ref_result(o, int'(x), int'(y), int'(c)));
    check({tag, "_carry"}, {31'd0, carry_out}, ref_carry(o, int'(x), int'(y), int'(c)));
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  initial begin
    int done_n;
    int done_at;
    int k;
    logic [WIDTH-1:0] bx [3];
    logic [WIDTH-1:0] by [3];

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_result", {24'd0, result}, 0);
    check("rst_carry", {31'd0, carry_out}, 0);
    check("rst_slice", {27'd0, alu_a, alu_b, alu_cin, alu_c}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed operations
    run_op("add_5a_3c", 2'b01, 8'h5A, 8'h3C, 1'b0);
    run_op("add_ff_01", 2'b01, 8'hFF, 8'h01, 1'b0);
    run_op("add_ff_00_cin", 2'b01, 8'hFF, 8'h00, 1'b1);
    run_op("and_f0_3c", 2'b10, 8'hF0, 8'h3C, 1'b1);
    run_op("not_0f", 2'b11, 8'h0F, 8'h55, 1'b0);
    run_op("pass_a5", 2'b00, 8'hA5, 8'hFF, 1'b1);

    // start during SHIFT and during DONE is ignored
    @(negedge clk);
    op = 2'b01; a = 8'h12; b = 8'h34; cin_init = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_n = 0;
    done_at = -1;
    for (int i = 0; i < 30; i++) begin
      if (i == 3 || i == 8) begin
        op = 2'b11; a = 8'hEE; b = 8'hEE; cin_init = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_n++;
        done_at = i;
        check("ign_result", {24'd0, result}, 8'h46);
        check("ign_carry", {31'd0, carry_out}, 0);
      end
      if (i > WIDTH + 1 && busy) check("ign_no_restart", {31'd0, busy}, 0);
      @(negedge clk);
    end
    check("ign_done_count", done_n, 1);
    check("ign_done_at", done_at, WIDTH + 1);

    // Reset in the middle of SHIFT aborts without done
    run_op("add_ff_01_pre", 2'b01, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    op = 2'b01; a = 8'h77; b = 8'h11; cin_init = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_result", {24'd0, result}, 0);
    check("abort_carry", {31'd0, carry_out}, 0);
    check("abort_slice", {27'd0, alu_a, alu_b, alu_cin, alu_c}, 0);
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) done_n++;
    end
    check("abort_no_done", done_n, 0);
    run_op("post_abort_add", 2'b01, 8'h01, 8'h01, 1'b0);

    // start held high: back-to-back operations every WIDTH+2 cycles
    bx[0] = 8'h80; by[0] = 8'h80;
    bx[1] = 8'h3C; by[1] = 8'hC3;
    bx[2] = 8'h7F; by[2] = 8'h01;
    @(negedge clk);
    op = 2'b01; a = bx[0]; b = by[0]; cin_init = 1'b0; start = 1'b1;
    @(negedge clk);
    k = 0;
    for (int i = 0; i < 3 * (WIDTH + 2) + 5; i++) begin
      if (done) begin
        if (k < 3) begin
          check("b2b_done_at", i, k * (WIDTH + 2) + WIDTH + 1);
          check("b2b_result", {24'd0, result}, ref_result(2'b01, int'(bx[k]), int'(by[k]), 0));
          check("b2b_carry", {31'd0, carry_out}, ref_carry(2'b01, int'(bx[k]), int'(by[k]), 0));
        end
        k++;
        if (k < 3) begin
          a = bx[k]; b = by[k];
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b_done_count", k, 3);

    // Randomised operations against the word-level reference
    for (int n = 0; n < 24; n++) begin
      run_op("rand", 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
